// File: rtl/beat_tracker.sv
// beat_tracker: onset filtering, 4-interval tempo averaging, sequential BPM divider
// and beat/downbeat pulse generation for the display path.
module beat_tracker #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned MIN_BPM      = 40,
    parameter int unsigned MAX_BPM      = 240,
    parameter int unsigned PULSE_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       onset,
    output logic [1:0] beat_pulse,
    output logic [8:0] bpm_estimate,
    output logic       locked
);
    localparam logic [31:0] DIVIDEND = 32'(CLK_HZ * 60);
    localparam logic [31:0] MAX_INT  = 32'(DIVIDEND / MIN_BPM);
    localparam logic [31:0] MIN_INT  = 32'(DIVIDEND / MAX_BPM);
    localparam int unsigned PW       = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic             w_load;
    logic [31:0]      r_ivl;
    logic             r_seq;
    logic [3:0][31:0] r_fifo;
    logic [33:0]      r_sum;
    logic [2:0]       r_cnt;
    logic [1:0]       r_idx;
    logic [31:0]      r_div, r_rem, r_quo;
    logic [4:0]       r_iter;
    logic             r_pend;
    logic [8:0]       r_bpm;
    logic             r_lock;
    logic [PW-1:0]    r_p0, r_p1;

    logic        w_timeout, w_first, w_acc, w_beat, w_down, w_start;
    logic [33:0] w_sum_nx;
    logic [32:0] w_shift, w_diff;

    assign w_timeout = r_seq && (r_ivl == MAX_INT);
    assign w_first   = onset && (!r_seq || w_timeout);
    assign w_acc     = onset && r_seq && !w_timeout && (r_ivl >= MIN_INT);
    assign w_beat    = w_first || w_acc;
    assign w_down    = w_first || (w_acc && r_idx == 2'd3);
    assign w_start   = w_acc && (r_cnt >= 3'd3);
    // fifo[3] is the oldest entry; it is zero until four intervals exist
    assign w_sum_nx  = w_acc ? r_sum + {2'b0, r_ivl} - {2'b0, r_fifo[3]} : r_sum;
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_div};

    assign beat_pulse   = {r_p1 != '0, r_p0 != '0};
    assign bpm_estimate = r_bpm;
    assign locked       = r_lock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nx = w_start ? S_DIV : S_IDLE;
                w_load     = w_start;
            end
            S_DIV:  w_state_nx = w_timeout ? S_IDLE : (r_iter == 5'd31) ? S_DONE : S_DIV;
            S_DONE: begin
                w_state_nx = (!w_timeout && (r_pend || w_start)) ? S_DIV : S_IDLE;
                w_load     = !w_timeout && (r_pend || w_start);
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ivl  <= '0;
            r_seq  <= 1'b0;
            r_fifo <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_div  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_iter <= '0;
            r_pend <= 1'b0;
            r_bpm  <= '0;
            r_lock <= 1'b0;
            r_p0   <= '0;
            r_p1   <= '0;
        end else begin
            r_ivl <= w_beat ? 32'd1 : (r_ivl < MAX_INT) ? r_ivl + 32'd1 : r_ivl;
            if (w_timeout || w_first) begin
                r_fifo <= '0;
                r_sum  <= '0;
                r_cnt  <= '0;
                r_idx  <= '0;
                r_seq  <= w_first;
            end else if (w_acc) begin
                r_fifo <= {r_fifo[2:0], r_ivl};
                r_sum  <= w_sum_nx;
                r_cnt  <= (r_cnt == 3'd4) ? r_cnt : r_cnt + 3'd1;
                r_idx  <= r_idx + 2'd1;
            end
            // a qualifying beat mid-division is remembered and re-divided after DONE
            r_pend <= (r_state == S_DIV) && !w_timeout && (r_pend || w_start);
            if (w_load) begin
                r_div  <= 32'(w_sum_nx >> 2);
                r_rem  <= '0;
                r_quo  <= DIVIDEND;
                r_iter <= '0;
            end else if (r_state == S_DIV) begin
                r_rem  <= w_diff[32] ? 32'(w_shift) : w_diff[31:0];
                r_quo  <= {r_quo[30:0], ~w_diff[32]};
                r_iter <= r_iter + 5'd1;
            end
            if (w_timeout) begin
                r_bpm  <= '0;
                r_lock <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_bpm  <= (|r_quo[31:9]) ? 9'd511 : r_quo[8:0];
                r_lock <= 1'b1;
            end
            r_p0 <= w_beat ? PW'(PULSE_CYCLES) : (r_p0 != '0) ? r_p0 - PW'(1) : r_p0;
            r_p1 <= w_down ? PW'(PULSE_CYCLES) : (r_p1 != '0) ? r_p1 - PW'(1) : r_p1;
        end
    end
endmodule
